// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul operand path.
// Contents: operand width, default frame sync byte, loader FSM state encoding.
package matmul_pkg;

    localparam int unsigned OPERAND_W     = 32;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoadX  = 3'd1,
        StLoadY  = 3'd2,
        StChk    = 3'd3,
        StCommit = 3'd4
    } loader_state_e;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte timeout counter for the operand loader.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear (has priority over i_en)
//   i_en           : count one cycle
//   o_expired      : counter has reached Limit-1
module frame_timeout_ctr #(
    parameter int unsigned Width = 17,
    parameter int unsigned Limit = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [Width-1:0] r_cnt;

    assign o_expired = (r_cnt == Width'(Limit - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            // Saturate so a stalled enable cannot wrap back to "not expired".
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_operand_loader.sv
// Frames the UART byte stream (SYNC, X[31:0] MSB first, Y[31:0] MSB first, CHK) into the two
// matmul operands and writes them to the operand RAM once per good frame.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid   : received byte and its one-cycle strobe
//   i_ram_read              : RAM read in progress; the write is held off while set
//   o_x, o_y                : last committed operands (registered)
//   o_write, o_utrig, o_cs  : RAM write strobe, feed trigger and chip select (combinational)
//   o_busy                  : loader is not idle
//   o_frame_ok, o_frame_err : one-cycle registered status pulses
//   o_overrun               : sticky, a byte arrived while committing
module uart_operand_loader
    import matmul_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned TO_W        = 17
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    input  logic                 i_ram_read,
    output logic [OPERAND_W-1:0] o_x,
    output logic [OPERAND_W-1:0] o_y,
    output logic                 o_write,
    output logic                 o_utrig,
    output logic                 o_cs,
    output logic                 o_busy,
    output logic                 o_frame_ok,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    loader_state_e        r_state, w_state_nxt;
    logic [OPERAND_W-1:0] r_xs, r_ys, r_x, r_y;
    logic [7:0]           r_chk;
    logic [1:0]           r_byte_cnt;
    logic                 r_frame_ok, r_frame_err, r_overrun;

    logic w_in_frame, w_to_expired, w_timeout, w_chk_match, w_chk_bad, w_commit_wr, w_sync;

    assign w_in_frame  = (r_state == StLoadX) || (r_state == StLoadY) || (r_state == StChk);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign w_timeout   = w_in_frame && w_to_expired && !i_rx_valid;
    assign w_sync      = (r_state == StIdle) && i_rx_valid && (i_rx_data == SYNC_BYTE);
    assign w_chk_match = (r_state == StChk) && i_rx_valid && (i_rx_data == r_chk);
    assign w_chk_bad   = (r_state == StChk) && i_rx_valid && (i_rx_data != r_chk);
    assign w_commit_wr = (r_state == StCommit) && !i_ram_read;

    frame_timeout_ctr #(
        .Width (TO_W),
        .Limit (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!w_in_frame || i_rx_valid),
        .i_en      (w_in_frame && !i_rx_valid),
        .o_expired (w_to_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_sync) w_state_nxt = StLoadX;
            end
            StLoadX: begin
                if (i_rx_valid && (r_byte_cnt == 2'd3)) w_state_nxt = StLoadY;
                else if (w_timeout)                     w_state_nxt = StIdle;
            end
            StLoadY: begin
                if (i_rx_valid && (r_byte_cnt == 2'd3)) w_state_nxt = StChk;
                else if (w_timeout)                     w_state_nxt = StIdle;
            end
            StChk: begin
                if (w_chk_match)                 w_state_nxt = StCommit;
                else if (w_chk_bad || w_timeout) w_state_nxt = StIdle;
            end
            StCommit: begin
                if (!i_ram_read) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xs        <= '0;
            r_ys        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_chk       <= '0;
            r_byte_cnt  <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_ok  <= w_commit_wr;
            r_frame_err <= w_chk_bad || w_timeout;
            if ((r_state == StCommit) && i_rx_valid) r_overrun <= 1'b1;

            if (w_sync) begin
                r_chk      <= '0;
                r_byte_cnt <= '0;
            end
            if (i_rx_valid && (r_state == StLoadX)) begin
                r_xs       <= {r_xs[OPERAND_W-9:0], i_rx_data};
                r_chk      <= r_chk ^ i_rx_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (i_rx_valid && (r_state == StLoadY)) begin
                r_ys       <= {r_ys[OPERAND_W-9:0], i_rx_data};
                r_chk      <= r_chk ^ i_rx_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_chk_match) begin
                r_x <= r_xs;
                r_y <= r_ys;
            end
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_write     = w_commit_wr;
    assign o_utrig     = w_commit_wr;
    assign o_cs        = w_commit_wr;
    assign o_busy      = (r_state != StIdle);
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_operand_loader.sv
module tb_uart_operand_loader;

    localparam int KWrite = 0;
    localparam int KOk    = 1;
    localparam int KErr   = 2;

    typedef struct {
        int          kind;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        ram_read = 1'b0;
    logic [31:0] x, y;
    logic        wr, utrig, cs, busy, frame_ok, frame_err, overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    logic prev_wr = 1'b0;

    always #5 clk = ~clk;

    uart_operand_loader #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (16),
        .TO_W        (5)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_ram_read  (ram_read),
        .o_x         (x),
        .o_y         (y),
        .o_write     (wr),
        .o_utrig     (utrig),
        .o_cs        (cs),
        .o_busy      (busy),
        .o_frame_ok  (frame_ok),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] ex, input logic [31:0] ey);
        exp_t e;
        e.kind = kind;
        e.x    = ex;
        e.y    = ey;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or status pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wr || utrig || cs)
                check("strobes_equal", {29'd0, wr, utrig, cs}, {29'd0, wr, wr, wr});
            if (wr) begin
                check("single_write_cycle", {31'd0, prev_wr}, 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("write_kind", e.kind, KWrite);
                    check("write_x", x, e.x);
                    check("write_y", y, e.y);
                end
            end
            if (frame_ok) begin
                check("ok_after_write", {31'd0, prev_wr}, 32'd1);
                if (q.size() == 0) begin
                    check("unexpected_frame_ok", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("frame_ok_kind", e.kind, KOk);
                end
            end
            if (frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_frame_err", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("frame_err_kind", e.kind, KErr);
                end
            end
        end
        prev_wr = wr;
    end

    // All tasks start and end at posedge + 1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_payload(input logic [31:0] px, input logic [31:0] py);
        send_byte(8'hA5);
        for (int i = 3; i >= 0; i--) send_byte(px[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(py[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            idle(1);
            k++;
        end
        idle(3);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_queue_drained"}, q.size(), 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        int wr_cnt;

        // Reset state
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_x", x, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_strobes", {29'd0, wr, utrig, cs}, 32'd0);
        check("rst_flags", {29'd0, frame_ok, frame_err, overrun}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 1: good frame
        push(KWrite, 32'h3, 32'h5);
        push(KOk, 0, 0);
        send_payload(32'h3, 32'h5);
        send_byte(8'h06);
        wait_idle("t1");
        check("t1_x", x, 32'h3);
        check("t1_y", y, 32'h5);

        // 2: bad checksum
        push(KErr, 0, 0);
        send_payload(32'h3, 32'h5);
        send_byte(8'h07);
        wait_idle("t2");
        check("t2_x_kept", x, 32'h3);
        check("t2_y_kept", y, 32'h5);

        // 3: read holds off the write for 10 cycles
        push(KWrite, 32'h3, 32'h5);
        push(KOk, 0, 0);
        send_payload(32'h3, 32'h5);
        ram_read = 1'b1;
        send_byte(8'h06);
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr) wr_cnt++;
            @(posedge clk);
            #1;
        end
        check("t3_no_write_while_read", wr_cnt, 32'd0);
        check("t3_busy_held", {31'd0, busy}, 32'd1);
        ram_read = 1'b0;
        wait_idle("t3");

        // 5: garbage byte, then sync values inside payload
        send_byte(8'h3C);
        idle(1);
        check("t5_garbage_ignored", {31'd0, busy}, 32'd0);
        push(KWrite, 32'hA5A5A5A5, 32'h0);
        push(KOk, 0, 0);
        send_payload(32'hA5A5A5A5, 32'h0);
        send_byte(8'h00);
        wait_idle("t5");
        check("t5_x", x, 32'hA5A5A5A5);
        check("t5_y", y, 32'h0);

        // 4: timeout after A5,11,22
        push(KErr, 0, 0);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        seen = 0;
        for (cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (frame_err && seen == 0) seen = cyc;
        end
        @(posedge clk);
        #1;
        check("t4_timeout_cycle", seen, 32'd17);
        check("t4_back_idle", {31'd0, busy}, 32'd0);
        check("t4_queue_drained", q.size(), 32'd0);
        push(KWrite, 32'h01020304, 32'h10203040);
        push(KOk, 0, 0);
        send_payload(32'h01020304, 32'h10203040);
        send_byte(8'h44);
        wait_idle("t4b");
        check("t4b_x", x, 32'h01020304);

        // 6a: overrun during a held commit
        check("t6_overrun_clear", {31'd0, overrun}, 32'd0);
        push(KWrite, 32'h3, 32'h5);
        push(KOk, 0, 0);
        send_payload(32'h3, 32'h5);
        ram_read = 1'b1;
        send_byte(8'h06);
        idle(2);
        send_byte(8'h77);
        check("t6_overrun_set", {31'd0, overrun}, 32'd1);
        idle(2);
        ram_read = 1'b0;
        wait_idle("t6a");
        check("t6_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 6b: async reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst_n = 1'b0;
        #2;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_x", x, 32'd0);
        check("t6_rst_y", y, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        push(KWrite, 32'h3, 32'h5);
        push(KOk, 0, 0);
        send_payload(32'h3, 32'h5);
        send_byte(8'h06);
        wait_idle("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
